udp_tx_sched: RTL

// Round-robin packet scheduler sharing the udp_top write port (wr_data/wr_valid/wr_last/wr_ready)

---
 rtl/udp_tx_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/udp_tx_sched.sv
// Round-robin packet scheduler: grants one sample source per packet and emits
// {ch_id, seq} header, PKT_WORDS payload words (or a PAD close-out on stall), last on final word.
module udp_tx_sched #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 4,
  parameter int PKT_WORDS = 10,
  parameter int TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] PAD = 16'hDEAD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy,
  output logic [15:0]              pkt_cnt,
  output logic [15:0]              to_cnt
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WC_W  = $clog2(PKT_WORDS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SEQ_W = DATA_W - 4;

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PADW, DONE} state_t;

  state_t             state;
  logic [CH_W-1:0]    gnt;
  logic [CH_W-1:0]    rr;
  logic [SEQ_W-1:0]   seq [NUM_CH];
  logic [WC_W-1:0]    wc;
  logic [TO_W-1:0]    idle_cnt;
  logic               loadable;
  logic               found;
  logic [CH_W-1:0]    pick;
  int                 idx;
  logic               cur_valid;
  logic [DATA_W-1:0]  cur_data;

  assign loadable  = !m_valid || m_ready;
  assign busy      = (state != IDLE);
  assign cur_valid = s_valid[gnt];
  assign cur_data  = s_data[int'(gnt)*DATA_W +: DATA_W];

  // Round-robin pick: scanning downward lets the nearest channel after rr win.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(rr) + i) % NUM_CH;
      if (s_valid[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Only the granted channel sees ready, and only while the output can take a word.
  always_comb begin
    s_ready = '0;
    if (state == PAYLOAD) begin
      s_ready[gnt] = loadable;
    end else begin
      s_ready = '0;
    end
  end

  // Packet FSM with registered output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr       <= CH_W'(NUM_CH - 1);
      wc       <= '0;
      idle_cnt <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      pkt_cnt  <= 16'd0;
      to_cnt   <= 16'd0;
      for (int i = 0; i < NUM_CH; i++) seq[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && found) begin
            gnt   <= pick;
            rr    <= pick;
            state <= HDR;
          end
        end
        HDR: begin
          if (loadable) begin
            m_data   <= {4'(gnt), seq[gnt]};
            m_valid  <= 1'b1;
            m_last   <= 1'b0;
            wc       <= '0;
            idle_cnt <= '0;
            state    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (loadable) begin
            if (cur_valid) begin
              m_data   <= cur_data;
              m_valid  <= 1'b1;
              m_last   <= (wc == WC_W'(PKT_WORDS - 1));
              wc       <= wc + WC_W'(1);
              idle_cnt <= '0;
              if (wc == WC_W'(PKT_WORDS - 1)) state <= DONE;
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              // The TIMEOUT-th consecutive idle cycle closes the packet.
              if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                idle_cnt <= '0;
                state    <= PADW;
              end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
              end
            end
          end
        end
        PADW: begin
          if (loadable) begin
            m_data  <= PAD;
            m_valid <= 1'b1;
            m_last  <= 1'b1;
            to_cnt  <= to_cnt + 16'd1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (m_valid && m_ready) begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            seq[gnt]   <= seq[gnt] + SEQ_W'(1);
            pkt_cnt    <= pkt_cnt + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
